// File: rtl/gpio_ctrl_if.sv
// Core-side register bus for gpio_ctrl: byte address, write data,
// single-cycle write strobe and combinational read data.
//   master : core side (drives Adr_in, Data_in, We_in; receives Data_out)
//   slave  : gpio_ctrl side (receives Adr_in, Data_in, We_in; drives Data_out)
interface gpio_ctrl_if;
    logic [31:0] Adr_in;
    logic [31:0] Data_in;
    logic        We_in;
    logic [31:0] Data_out;

    modport master (
        output Adr_in,
        output Data_in,
        output We_in,
        input  Data_out
    );

    modport slave (
        input  Adr_in,
        input  Data_in,
        input  We_in,
        output Data_out
    );
endinterface

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO block: output/direction registers, synchronised
// inputs, rise/fall edge detection into a sticky W1C status register.
// Ports:
//   clk, rst      : clock (rising edge), async active-high reset
//   bus           : register bus (slave side), 32-bit addr/data
//   pins_in       : asynchronous external inputs
//   pins_out      : output drive values (OUT register)
//   pins_oe       : per-pin output enable (DIR register)
//   irq           : level interrupt, |(STAT & IE), registered
module gpio_ctrl #(
    parameter int          WIDTH   = 8,
    parameter logic [15:0] BASE_HI = 16'h1001,
    parameter logic [15:0] BASE_LO = 16'h0024
) (
    input  logic             clk,
    input  logic             rst,
    gpio_ctrl_if.slave       bus,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] pins_out,
    output logic [WIDTH-1:0] pins_oe,
    output logic             irq
);

    logic [WIDTH-1:0] out_q, dir_q, ie_q, stat_q, rise_q, fall_q;
    logic [WIDTH-1:0] out_nxt, dir_nxt, ie_nxt, stat_nxt;
    logic [WIDTH-1:0] rise_nxt, fall_nxt;
    logic [WIDTH-1:0] s1_q, s2_q, s3_q;
    logic [WIDTH-1:0] wd, ev, clr, rd;
    logic [15:0]      off;
    logic             page_hit;
    logic             sel_out, sel_in, sel_dir, sel_ie;
    logic             sel_stat, sel_rise, sel_fall;
    logic [31:0]      rd32;
    logic             unused_data;

    assign wd          = bus.Data_in[WIDTH-1:0];
    assign unused_data = ^bus.Data_in;

    // Offset wraps modulo 2^16, so addresses below BASE_LO miss.
    assign page_hit = (bus.Adr_in[31:16] == BASE_HI);
    assign off      = bus.Adr_in[15:0] - BASE_LO;

    always_comb begin
        sel_out  = 1'b0;
        sel_in   = 1'b0;
        sel_dir  = 1'b0;
        sel_ie   = 1'b0;
        sel_stat = 1'b0;
        sel_rise = 1'b0;
        sel_fall = 1'b0;
        if (page_hit) begin
            case (off)
                16'h0000: sel_out  = 1'b1;
                16'h0004: sel_in   = 1'b1;
                16'h0008: sel_dir  = 1'b1;
                16'h000C: sel_ie   = 1'b1;
                16'h0010: sel_stat = 1'b1;
                16'h0014: sel_rise = 1'b1;
                16'h0018: sel_fall = 1'b1;
                default:  ;
            endcase
        end
    end

    // Edge events from the synchronised sample and its history flop.
    assign ev  = (s2_q & ~s3_q & rise_q) | (~s2_q & s3_q & fall_q);
    assign clr = (bus.We_in && sel_stat) ? wd : '0;

    always_comb begin
        out_nxt  = out_q;
        dir_nxt  = dir_q;
        ie_nxt   = ie_q;
        rise_nxt = rise_q;
        fall_nxt = fall_q;
        if (bus.We_in) begin
            if (sel_out)  out_nxt  = wd;
            if (sel_dir)  dir_nxt  = wd;
            if (sel_ie)   ie_nxt   = wd;
            if (sel_rise) rise_nxt = wd;
            if (sel_fall) fall_nxt = wd;
        end
        // Set has priority over a same-cycle clear.
        stat_nxt = (stat_q & ~clr) | ev;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            dir_q  <= '0;
            ie_q   <= '0;
            stat_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            irq    <= 1'b0;
        end else begin
            out_q  <= out_nxt;
            dir_q  <= dir_nxt;
            ie_q   <= ie_nxt;
            stat_q <= stat_nxt;
            rise_q <= rise_nxt;
            fall_q <= fall_nxt;
            s1_q   <= pins_in;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            // Registered from next-state so irq tracks STAT/IE
            // on the same edge without combinational glitches.
            irq    <= |(stat_nxt & ie_nxt);
        end
    end

    always_comb begin
        rd = '0;
        if (sel_out)  rd = out_q;
        if (sel_in)   rd = s2_q;
        if (sel_dir)  rd = dir_q;
        if (sel_ie)   rd = ie_q;
        if (sel_stat) rd = stat_q;
        if (sel_rise) rd = rise_q;
        if (sel_fall) rd = fall_q;
    end

    always_comb begin
        rd32             = '0;
        rd32[WIDTH-1:0]  = rd;
    end

    assign bus.Data_out = rd32;
    assign pins_out     = out_q;
    assign pins_oe      = dir_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed self-checking bench for gpio_ctrl (WIDTH=8 and WIDTH=4).
// Ports: none.
module tb_gpio_ctrl;

    localparam logic [31:0] BASE = 32'h1001_0024;
    localparam logic [31:0] R_OUT  = BASE + 32'h00;
    localparam logic [31:0] R_IN   = BASE + 32'h04;
    localparam logic [31:0] R_DIR  = BASE + 32'h08;
    localparam logic [31:0] R_IE   = BASE + 32'h0C;
    localparam logic [31:0] R_STAT = BASE + 32'h10;
    localparam logic [31:0] R_RISE = BASE + 32'h14;
    localparam logic [31:0] R_FALL = BASE + 32'h18;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pins8;
    logic [7:0] pout8, poe8;
    logic       irq8;
    logic [3:0] pins4;
    logic [3:0] pout4, poe4;
    logic       irq4;

    int errors = 0;
    int checks = 0;

    gpio_ctrl_if bus8 ();
    gpio_ctrl_if bus4 ();

    gpio_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8),
        .pins_in(pins8), .pins_out(pout8),
        .pins_oe(poe8), .irq(irq8)
    );

    gpio_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4),
        .pins_in(pins4), .pins_out(pout4),
        .pins_oe(poe4), .irq(irq4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr8(input logic [31:0] a, input logic [31:0] d);
        bus8.Adr_in  = a;
        bus8.Data_in = d;
        bus8.We_in   = 1'b1;
        @(posedge clk);
        #1;
        bus8.We_in   = 1'b0;
    endtask

    task automatic rd8(input logic [31:0] a, output logic [31:0] d);
        bus8.Adr_in = a;
        #1;
        d = bus8.Data_out;
    endtask

    task automatic wr4(input logic [31:0] a, input logic [31:0] d);
        bus4.Adr_in  = a;
        bus4.Data_in = d;
        bus4.We_in   = 1'b1;
        @(posedge clk);
        #1;
        bus4.We_in   = 1'b0;
    endtask

    task automatic rd4(input logic [31:0] a, output logic [31:0] d);
        bus4.Adr_in = a;
        #1;
        d = bus4.Data_out;
    endtask

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] d;

    initial begin
        pins8 = 8'h00;
        pins4 = 4'h0;
        bus8.Adr_in = '0; bus8.Data_in = '0; bus8.We_in = 1'b0;
        bus4.Adr_in = '0; bus4.Data_in = '0; bus4.We_in = 1'b0;

        // Reset state, and a write during reset is ignored.
        edge1();
        wr8(R_OUT, 32'hFF);
        check("rst_pins_out", {24'h0, pout8}, 32'h0);
        check("rst_pins_oe", {24'h0, poe8}, 32'h0);
        check("rst_irq", {31'h0, irq8}, 32'h0);
        rst = 1'b0;
        edge1();

        // OUT/DIR writes, upper Data_in bits dropped.
        wr8(R_OUT, 32'hFFFF_FFA5);
        wr8(R_DIR, 32'hFF);
        check("pins_out_a5", {24'h0, pout8}, 32'hA5);
        check("pins_oe_ff", {24'h0, poe8}, 32'hFF);
        rd8(R_OUT, d);
        check("rd_out", d, 32'h0000_00A5);
        rd8(R_DIR, d);
        check("rd_dir", d, 32'h0000_00FF);

        // Writes to IN and to a miss are ignored.
        wr8(R_IN, 32'hFF);
        rd8(R_IN, d);
        check("in_ro", d, 32'h0);
        wr8(32'h1002_0024, 32'h11);
        rd8(R_OUT, d);
        check("miss_wr", d, 32'hA5);
        rd8(BASE + 32'h1C, d);
        check("miss_rd_1c", d, 32'h0);
        rd8(BASE - 32'h4, d);
        check("miss_rd_below", d, 32'h0);

        // Synchroniser latency: change after edge N.
        pins8 = 8'h3C;
        edge1();
        rd8(R_IN, d);
        check("in_n1", d, 32'h00);
        edge1();
        rd8(R_IN, d);
        check("in_n2", d, 32'h3C);
        edge1();
        rd8(R_STAT, d);
        check("no_ev_rise0", d, 32'h0);

        // Rising event on pin0 with IE set.
        pins8 = 8'h00;
        repeat (4) edge1();
        wr8(R_RISE, 32'h01);
        wr8(R_IE, 32'h01);
        pins8 = 8'h01;
        edge1();
        check("irq_n1", {31'h0, irq8}, 32'h0);
        edge1();
        rd8(R_STAT, d);
        check("stat_n2", d, 32'h0);
        check("irq_n2", {31'h0, irq8}, 32'h0);
        edge1();
        rd8(R_STAT, d);
        check("stat_n3", d, 32'h01);
        check("irq_n3", {31'h0, irq8}, 32'h1);
        wr8(R_STAT, 32'h01);
        rd8(R_STAT, d);
        check("stat_w1c", d, 32'h0);
        check("irq_w1c", {31'h0, irq8}, 32'h0);

        // Fall event collides with a W1C of the same bit.
        wr8(R_FALL, 32'h01);
        pins8 = 8'h00;
        edge1();
        edge1();
        wr8(R_STAT, 32'h01);
        rd8(R_STAT, d);
        check("set_wins", d, 32'h01);
        check("irq_set_wins", {31'h0, irq8}, 32'h1);

        // Sticky vs IE/RISE/FALL, zero bits of W1C do nothing.
        wr8(R_IE, 32'h00);
        check("irq_ie0", {31'h0, irq8}, 32'h0);
        wr8(R_RISE, 32'h00);
        wr8(R_FALL, 32'h00);
        wr8(R_STAT, 32'hFE);
        rd8(R_STAT, d);
        check("stat_sticky", d, 32'h01);
        wr8(R_IE, 32'h01);
        check("irq_ie1", {31'h0, irq8}, 32'h1);
        wr8(R_STAT, 32'h01);
        rd8(R_STAT, d);
        check("stat_clr2", d, 32'h0);

        // WIDTH=4 instance.
        wr4(R_OUT, 32'hFFFF_FFFF);
        rd4(R_OUT, d);
        check("w4_rd_out", d, 32'h0000_000F);
        check("w4_pins_out", {28'h0, pout4}, 32'hF);
        rd4(BASE + 32'h1C, d);
        check("w4_miss_1c", d, 32'h0);
        rd4(32'h2001_0024, d);
        check("w4_miss_page", d, 32'h0);

        // Mid-cycle async reset with OUT=0x55, STAT=0x02.
        wr8(R_OUT, 32'h55);
        wr8(R_RISE, 32'h02);
        wr8(R_IE, 32'h02);
        pins8 = 8'h02;
        repeat (3) edge1();
        rd8(R_STAT, d);
        check("pre_rst_stat", d, 32'h02);
        check("pre_rst_irq", {31'h0, irq8}, 32'h1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_pins_out", {24'h0, pout8}, 32'h0);
        check("arst_pins_oe", {24'h0, poe8}, 32'h0);
        check("arst_irq", {31'h0, irq8}, 32'h0);
        rd8(R_STAT, d);
        check("arst_stat", d, 32'h0);
        check("arst_w4_out", {28'h0, pout4}, 32'h0);
        edge1();
        rst = 1'b0;

        // Pin already high after reset, RISE still 0: no event.
        repeat (4) edge1();
        rd8(R_STAT, d);
        check("post_rst_stat", d, 32'h0);
        rd8(R_IN, d);
        check("post_rst_in", d, 32'h02);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gpio_ctrl.md
GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter WIDTH, default 8, meaning pin count (legal 1..32).
REQ-003 SHALL have parameter BASE_HI, default 16'h1001, meaning required value of Adr_in[31:16].
REQ-004 SHALL have parameter BASE_LO, default 16'h0024, meaning block offset within the BASE_HI page.
REQ-005 SHALL have port clk  in  1  system clock, rising-edge active.
REQ-006 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have port Adr_in  in  32  byte address from core.
REQ-008 SHALL have port Data_in  in  32  write data.
REQ-009 SHALL have port We_in  in  1  write strobe, one cycle per write.
REQ-010 SHALL have port Data_out  out  32  read data.
REQ-011 SHALL have port pins_in  in  WIDTH  asynchronous external inputs (switches).
REQ-012 SHALL have port pins_out  out  WIDTH  output drive values (LEDs).
REQ-013 SHALL have port pins_oe  out  WIDTH  per-pin output enable, 1 = drive.
REQ-014 SHALL have port irq  out  1  level interrupt request.

Function
REQ-015 SHALL decode a hit when Adr_in[31:16]==BASE_HI and Adr_in[15:0]-BASE_LO is one of the register offsets below; all other addresses are misses.
REQ-016 SHALL implement registers, WIDTH bits each: 0x00 OUT (RW), 0x04 IN (RO), 0x08 DIR (RW), 0x0C IE (RW), 0x10 STAT (W1C), 0x14 RISE (RW), 0x18 FALL (RW).
REQ-017 SHALL update a RW register at the clk edge where We_in=1 and a hit selects it, taking Data_in[WIDTH-1:0].
REQ-018 SHALL ignore writes to IN, writes on a miss, and Data_in bits at or above WIDTH.
REQ-019 SHALL drive Data_out combinationally from the addressed register, zero-extended to 32 bits, with 32'h0 on a miss; reads have no side effects.
REQ-020 SHALL drive pins_out = OUT and pins_oe = DIR directly from flops.
REQ-021 SHALL pass pins_in through a two-flop synchroniser (s1, s2) plus a history flop s3; IN reads s2, so a pin change is visible 2 edges later.
REQ-022 SHALL flag a rising event when s2&~s3&RISE and a falling event when ~s2&s3&FALL, per bit; an event sets STAT at the next edge (3 edges after the pin change).
REQ-023 SHALL clear STAT bits where a write to 0x10 has Data_in=1; zero bits leave STAT unchanged.
REQ-024 SHALL let the set win when an event and a W1C target the same STAT bit in the same cycle.
REQ-025 SHALL keep STAT bits sticky regardless of IE and of later RISE/FALL changes.
REQ-026 SHALL drive irq = |(STAT & IE), derived only from flops (glitch-free).
REQ-027 SHALL NOT gate events by DIR; output pins still sample pins_in.

Reset
REQ-028 SHALL asynchronously clear OUT, DIR, IE, STAT, RISE, FALL, s1, s2 and s3 to 0 on rst=1, so pins_out=0, pins_oe=0 and irq=0.
REQ-029 SHALL hold all flops at reset values while rst=1 and ignore writes during reset.
REQ-030 SHALL, after reset release, treat a pin already high as a rising transition; STAT is set only if RISE was enabled first.
REQ-031 SHALL abort a reset asserted mid-operation immediately, discarding pending events in flight.

Verification
REQ-032 SHALL cover: write 0xA5 to BASE+0x00, then 0xFF to BASE+0x08 -> pins_out=0xA5, pins_oe=0xFF; read BASE+0x00 gives 0x000000A5.
REQ-033 SHALL cover: pins_in 0x00->0x3C at edge N -> read BASE+0x04 gives 0x3C from edge N+2, 0x00 before.
REQ-034 SHALL cover: RISE=0x01, IE=0x01, pin0 0->1 -> STAT=0x01 and irq=1 at edge N+3; W1C 0x01 -> STAT=0, irq=0.
REQ-035 SHALL cover: a W1C of bit 0 in the same cycle as a new pin0 event -> STAT bit 0 remains 1.
REQ-036 SHALL cover: WIDTH=4, write 0xFFFFFFFF to OUT -> read gives 0x0000000F; a read of BASE+0x1C or of another page gives 0.
REQ-037 SHALL cover: rst pulsed mid-frame with OUT=0x55 and STAT=0x02 -> all outputs 0 asynchronously, irq=0 before the next clk edge.
